branch_issue_sched: RTL and testbench

- Scheduler for the branch execution unit: holds dispatched branch/jump micro-ops, wakes their operands from CDB broadcasts, and issues the oldest ready entry, one per cycle, into the single-entry branch unit.
- Tracks branch-unit occupancy through the CDB grant handshake.
- Squashes entries younger than a resolved mispredicted branch.
- Sits between dispatch/ROB and the branch unit; its issue_valid drives the unit's branch_enable.

---
 rtl/branch_issue_sched.sv | 89 ++++++++
 tb/tb_branch_issue_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_issue_sched.sv
// branch_issue_sched: oldest-ready branch scheduler with CDB wakeup, grant-tracked unit occupancy and mispredict squash (dispatch in, issue to branch unit out)
module branch_issue_sched #(
  parameter int RS_DEPTH = 4,
  parameter int ROB_LEN = 5,
  parameter int PRF_LEN = 6,
  parameter int PKT_W = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               disp_valid,
  input  logic [PKT_W-1:0]   disp_pkt,
  input  logic [ROB_LEN-1:0] disp_rob_idx,
  input  logic [PRF_LEN-1:0] disp_opa_preg,
  input  logic [PRF_LEN-1:0] disp_opb_preg,
  input  logic               disp_opa_ready,
  input  logic               disp_opb_ready,
  output logic               rs_full,
  input  logic               cdb_valid,
  input  logic [PRF_LEN-1:0] cdb_preg_idx,
  input  logic [ROB_LEN-1:0] rob_head_idx,
  output logic               issue_valid,
  output logic [PKT_W-1:0]   issue_pkt,
  output logic [ROB_LEN-1:0] issue_rob_idx,
  input  logic               cdb_grant_br,
  output logic               unit_busy,
  input  logic               mispred_valid,
  input  logic [ROB_LEN-1:0] mispred_rob_idx
);
  localparam int IW = $clog2(RS_DEPTH);
  logic [RS_DEPTH-1:0] valid, opa_rdy, opb_rdy;
  logic [PRF_LEN-1:0] opa_preg [RS_DEPTH];
  logic [PRF_LEN-1:0] opb_preg [RS_DEPTH];
  logic [ROB_LEN-1:0] rob_idx [RS_DEPTH];
  logic [PKT_W-1:0] pkt [RS_DEPTH];
  logic [ROB_LEN-1:0] age [RS_DEPTH];
  logic [ROB_LEN-1:0] best_age, mis_age;
  logic [IW-1:0] free_idx, sel_idx;
  logic have_cand, issue_go, disp_go;
  assign rs_full = &valid;
  assign mis_age = mispred_rob_idx - rob_head_idx;
  assign issue_go = have_cand && (!unit_busy || cdb_grant_br) && !mispred_valid;
  assign disp_go = disp_valid && !rs_full && !mispred_valid;
  always_comb begin
    free_idx = '0;
    have_cand = 1'b0;
    sel_idx = '0;
    best_age = '0;
    for (int i = 0; i < RS_DEPTH; i++) age[i] = rob_idx[i] - rob_head_idx;
    for (int i = RS_DEPTH - 1; i >= 0; i--) free_idx = valid[i] ? free_idx : IW'(i);
    for (int i = 0; i < RS_DEPTH; i++)
      if (valid[i] && opa_rdy[i] && opb_rdy[i] && (!have_cand || age[i] < best_age)) begin
        have_cand = 1'b1;
        sel_idx = IW'(i);
        best_age = age[i];
      end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      opa_rdy <= '0;
      opb_rdy <= '0;
      issue_valid <= 1'b0;
      issue_pkt <= '0;
      issue_rob_idx <= '0;
      unit_busy <= 1'b0;
    end else begin
      issue_valid <= issue_go;
      unit_busy <= issue_go ? 1'b1 : (mispred_valid || cdb_grant_br) ? 1'b0 : unit_busy;
      if (issue_go) begin
        issue_pkt <= pkt[sel_idx];
        issue_rob_idx <= rob_idx[sel_idx];
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (cdb_valid && opa_preg[i] == cdb_preg_idx) opa_rdy[i] <= 1'b1;
        if (cdb_valid && opb_preg[i] == cdb_preg_idx) opb_rdy[i] <= 1'b1;
        if ((issue_go && sel_idx == IW'(i)) || (mispred_valid && age[i] > mis_age)) valid[i] <= 1'b0;
        if (disp_go && free_idx == IW'(i)) begin
          valid[i] <= 1'b1;
          opa_rdy[i] <= disp_opa_ready || (cdb_valid && cdb_preg_idx == disp_opa_preg);
          opb_rdy[i] <= disp_opb_ready || (cdb_valid && cdb_preg_idx == disp_opb_preg);
          opa_preg[i] <= disp_opa_preg;
          opb_preg[i] <= disp_opb_preg;
          rob_idx[i] <= disp_rob_idx;
          pkt[i] <= disp_pkt;
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_issue_sched.sv
// tb_branch_issue_sched: directed self-checking bench for branch_issue_sched
module tb_branch_issue_sched;
  logic clock = 1'b0;
  logic reset;
  logic disp_valid;
  logic [127:0] disp_pkt;
  logic [4:0] disp_rob_idx;
  logic [5:0] disp_opa_preg, disp_opb_preg;
  logic disp_opa_ready, disp_opb_ready;
  logic rs_full;
  logic cdb_valid;
  logic [5:0] cdb_preg_idx;
  logic [4:0] rob_head_idx;
  logic issue_valid;
  logic [127:0] issue_pkt;
  logic [4:0] issue_rob_idx;
  logic cdb_grant_br;
  logic unit_busy;
  logic mispred_valid;
  logic [4:0] mispred_rob_idx;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  branch_issue_sched dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_pkt(disp_pkt), .disp_rob_idx(disp_rob_idx),
    .disp_opa_preg(disp_opa_preg), .disp_opb_preg(disp_opb_preg),
    .disp_opa_ready(disp_opa_ready), .disp_opb_ready(disp_opb_ready),
    .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_preg_idx(cdb_preg_idx),
    .rob_head_idx(rob_head_idx), .issue_valid(issue_valid), .issue_pkt(issue_pkt),
    .issue_rob_idx(issue_rob_idx), .cdb_grant_br(cdb_grant_br), .unit_busy(unit_busy),
    .mispred_valid(mispred_valid), .mispred_rob_idx(mispred_rob_idx)
  );

  function automatic logic [127:0] pk(input logic [4:0] rob);
    return {59'h0, rob, 64'hC0DE_0000_1234_5678};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0;
    disp_valid = 1'b0;
    disp_pkt = '0;
    disp_rob_idx = '0;
    disp_opa_preg = '0;
    disp_opb_preg = '0;
    disp_opa_ready = 1'b0;
    disp_opb_ready = 1'b0;
    cdb_valid = 1'b0;
    cdb_preg_idx = '0;
    cdb_grant_br = 1'b0;
    mispred_valid = 1'b0;
    mispred_rob_idx = '0;
  endtask

  task automatic disp(input logic [4:0] rob, input logic [5:0] ap, input logic ar, input logic [5:0] bp, input logic br);
    disp_valid = 1'b1;
    disp_rob_idx = rob;
    disp_pkt = pk(rob);
    disp_opa_preg = ap;
    disp_opa_ready = ar;
    disp_opb_preg = bp;
    disp_opb_ready = br;
  endtask

  task automatic test_reset();
    idle();
    rob_head_idx = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
    n_checks++; if (unit_busy !== 1'b0) begin n_fail++; $display("FAIL reset_unit_busy got %b want 0", unit_busy); end
    n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_rs_full got %b want 0", rs_full); end
    n_checks++; if (issue_pkt !== 128'h0) begin n_fail++; $display("FAIL reset_issue_pkt got %h want 0", issue_pkt); end
    n_checks++; if (issue_rob_idx !== 5'd0) begin n_fail++; $display("FAIL reset_issue_rob_idx got %0d want 0", issue_rob_idx); end
  endtask

  task automatic test_age_order();
    logic [4:0] robs [4] = '{5'd3, 5'd1, 5'd2, 5'd0};
    idle();
    rob_head_idx = '0;
    for (int k = 0; k < 4; k++) begin
      disp(robs[k], 6'd20, 1'b0, 6'd0, 1'b1);
      tick();
    end
    disp_valid = 1'b0;
    n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL order_rs_full got %b want 1", rs_full); end
    cdb_valid = 1'b1;
    cdb_preg_idx = 6'd20;
    tick();
    cdb_valid = 1'b0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL order_early_issue got %b want 0", issue_valid); end
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (issue_valid !== 1'b1 || issue_rob_idx !== 5'(k)) begin n_fail++; $display("FAIL order_issue_%0d got valid=%b rob=%0d want valid=1 rob=%0d", k, issue_valid, issue_rob_idx, k); end
      n_checks++; if (issue_pkt !== pk(5'(k))) begin n_fail++; $display("FAIL order_pkt_%0d got %h want %h", k, issue_pkt, pk(5'(k))); end
      cdb_grant_br = 1'b1;
      tick();
    end
    cdb_grant_br = 1'b0;
    n_checks++; if (issue_valid !== 1'b0 || unit_busy !== 1'b0) begin n_fail++; $display("FAIL order_drain got valid=%b busy=%b want 0 0", issue_valid, unit_busy); end
  endtask

  task automatic test_wakeup();
    idle();
    disp(5'd5, 6'd9, 1'b0, 6'd0, 1'b1);
    tick();
    disp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_hold_%0d got %b want 0", k, issue_valid); end
      tick();
    end
    cdb_valid = 1'b1;
    cdb_preg_idx = 6'd9;
    tick();
    cdb_valid = 1'b0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_plus1 got %b want 0", issue_valid); end
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_rob_idx !== 5'd5) begin n_fail++; $display("FAIL wakeup_plus2 got valid=%b rob=%0d want valid=1 rob=5", issue_valid, issue_rob_idx); end
    cdb_grant_br = 1'b1;
    tick();
    cdb_grant_br = 1'b0;
    n_checks++; if (unit_busy !== 1'b0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL wakeup_clear got busy=%b valid=%b want 0 0", unit_busy, issue_valid); end
  endtask

  task automatic test_bypass();
    idle();
    disp(5'd7, 6'd0, 1'b1, 6'd12, 1'b0);
    cdb_valid = 1'b1;
    cdb_preg_idx = 6'd12;
    tick();
    disp_valid = 1'b0;
    cdb_valid = 1'b0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_plus1 got %b want 0", issue_valid); end
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_rob_idx !== 5'd7) begin n_fail++; $display("FAIL bypass_plus2 got valid=%b rob=%0d want valid=1 rob=7", issue_valid, issue_rob_idx); end
    cdb_grant_br = 1'b1;
    tick();
    cdb_grant_br = 1'b0;
  endtask

  task automatic test_back_to_back();
    idle();
    disp(5'd10, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    disp(5'd11, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    disp_valid = 1'b0;
    n_checks++; if (issue_valid !== 1'b1 || issue_rob_idx !== 5'd10 || unit_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_first got valid=%b rob=%0d busy=%b want 1 10 1", issue_valid, issue_rob_idx, unit_busy); end
    tick();
    n_checks++; if (issue_valid !== 1'b0 || unit_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_stall1 got valid=%b busy=%b want 0 1", issue_valid, unit_busy); end
    tick();
    n_checks++; if (issue_valid !== 1'b0 || unit_busy !== 1'b1 || issue_rob_idx !== 5'd10) begin n_fail++; $display("FAIL b2b_stall2 got valid=%b busy=%b rob=%0d want 0 1 10", issue_valid, unit_busy, issue_rob_idx); end
    cdb_grant_br = 1'b1;
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_rob_idx !== 5'd11 || unit_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second got valid=%b rob=%0d busy=%b want 1 11 1", issue_valid, issue_rob_idx, unit_busy); end
    tick();
    cdb_grant_br = 1'b0;
    n_checks++; if (issue_valid !== 1'b0 || unit_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got valid=%b busy=%b want 0 0", issue_valid, unit_busy); end
  endtask

  task automatic test_flush();
    logic [4:0] robs [4] = '{5'd31, 5'd1, 5'd4, 5'd0};
    idle();
    rob_head_idx = 5'd30;
    for (int k = 0; k < 4; k++) begin
      disp(robs[k], 6'd40, 1'b0, 6'd0, 1'b1);
      tick();
    end
    n_checks++; if (rs_full !== 1'b1) begin n_fail++; $display("FAIL flush_full_before got %b want 1", rs_full); end
    rs_full_loop: begin end
    disp_valid = 1'b0;
    tick();
    disp(5'd2, 6'd0, 1'b1, 6'd0, 1'b1);
    mispred_valid = 1'b1;
    mispred_rob_idx = 5'd31;
    tick();
    idle();
    n_checks++; if (rs_full !== 1'b0) begin n_fail++; $display("FAIL flush_rs_full got %b want 0", rs_full); end
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped_disp got %b want 0", issue_valid); end
    cdb_valid = 1'b1;
    cdb_preg_idx = 6'd40;
    tick();
    cdb_valid = 1'b0;
    tick();
    n_checks++; if (issue_valid !== 1'b1 || issue_rob_idx !== 5'd31) begin n_fail++; $display("FAIL flush_retained got valid=%b rob=%0d want 1 31", issue_valid, issue_rob_idx); end
    cdb_grant_br = 1'b1;
    tick();
    cdb_grant_br = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_squashed_%0d got valid=%b rob=%0d want 0", k, issue_valid, issue_rob_idx); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    idle();
    rob_head_idx = '0;
    disp(5'd1, 6'd0, 1'b1, 6'd0, 1'b1);
    tick();
    for (int k = 2; k <= 4; k++) begin
      disp(5'(k), 6'd50, 1'b0, 6'd0, 1'b1);
      tick();
    end
    disp_valid = 1'b0;
    n_checks++; if (unit_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got %b want 1", unit_busy); end
    reset = 1'b1;
    cdb_valid = 1'b1;
    cdb_preg_idx = 6'd50;
    tick();
    reset = 1'b0;
    n_checks++; if (issue_valid !== 1'b0 || unit_busy !== 1'b0 || rs_full !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got valid=%b busy=%b full=%b want 0 0 0", issue_valid, unit_busy, rs_full); end
    n_checks++; if (issue_pkt !== 128'h0 || issue_rob_idx !== 5'd0) begin n_fail++; $display("FAIL midrst_outputs got pkt=%h rob=%0d want 0 0", issue_pkt, issue_rob_idx); end
    tick();
    cdb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_issue_%0d got %b want 0", k, issue_valid); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_age_order();
    test_wakeup();
    test_bypass();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
